stat_mem_arbiter: RTL and testbench

- Controller/arbiter for the per-flow statistics memory: serialises packet-size updates and host read requests onto one simple-dual-port RAM (1 read port, 1 write port, 1-cycle read latency, read-old-data on same-address collision).
- Performs saturating read-modify-write accumulation with hazard forwarding, and buffers bursts of updates in a small input FIFO.
- Sits between the packet-size/flow input and the stats RAM; also serves the host read interface.

---
 rtl/stat_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_stat_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_mem_arbiter.sv
// Per-flow statistics memory controller: arbitrates packet-size updates and host reads
// onto a 1R/1W RAM, doing saturating read-modify-write with S2/S3 hazard forwarding.
`timescale 1ns/1ps

module stat_mem_arbiter #(
  parameter int A_WIDTH    = 10,
  parameter int D_WIDTH    = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CLR_ON_RD  = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] upd_flow_i,
  input  logic [15:0]        upd_size_i,
  input  logic               upd_en_i,
  input  logic               rd_stb_i,
  input  logic [A_WIDTH-1:0] rd_flow_num_i,
  output logic               rd_busy_o,
  output logic [D_WIDTH-1:0] rd_data_o,
  output logic               rd_data_val_o,
  output logic               mem_rd_en_o,
  output logic [A_WIDTH-1:0] mem_rd_addr_o,
  input  logic [D_WIDTH-1:0] mem_rd_data_i,
  output logic               mem_wr_en_o,
  output logic [A_WIDTH-1:0] mem_wr_addr_o,
  output logic [D_WIDTH-1:0] mem_wr_data_o,
  output logic               fifo_full_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = A_WIDTH + 16;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Round-robin priority pointer
  //   state    | meaning
  //   PRI_UPD  | on contention the update FIFO wins
  //   PRI_HOST | on contention the pending host read wins
  typedef enum logic {PRI_UPD, PRI_HOST} pri_t;
  pri_t pri, pri_nxt;

  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop;
  logic [A_WIDTH-1:0] head_flow;
  logic [15:0]        head_size;

  logic               busy, issued;
  logic [A_WIDTH-1:0] rd_flow;
  logic               u_req, h_req, gnt_u, gnt_h;

  logic               s1_valid, s1_host;
  logic [A_WIDTH-1:0] s1_addr;
  logic [15:0]        s1_size;
  logic               s2_wr;
  logic [A_WIDTH-1:0] s2_addr;
  logic [D_WIDTH-1:0] s2_data;
  logic               s3_valid;
  logic [A_WIDTH-1:0] s3_addr;
  logic [D_WIDTH-1:0] s3_data;

  logic [D_WIDTH-1:0] old_val, sum_sat;
  logic [D_WIDTH:0]   sum_ext;

  assign head_flow = fifo_mem[rd_ptr][EW-1:16];
  assign head_size = fifo_mem[rd_ptr][15:0];
  assign u_req     = (count != '0);
  assign h_req     = busy && !issued;

  always_comb begin
    gnt_u   = 1'b0;
    gnt_h   = 1'b0;
    pri_nxt = pri;
    if (u_req && h_req) begin
      if (pri == PRI_HOST) gnt_h = 1'b1;
      else                 gnt_u = 1'b1;
      pri_nxt = (pri == PRI_HOST) ? PRI_UPD : PRI_HOST;
    end else if (u_req) begin
      gnt_u = 1'b1;
    end else if (h_req) begin
      gnt_h = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pri <= PRI_UPD;
    else        pri <= pri_nxt;
  end

  assign pop           = gnt_u;
  assign push          = upd_en_i && ((count < DEPTH_C) || pop);
  assign fifo_full_o   = (count == DEPTH_C);
  assign mem_rd_en_o   = gnt_u | gnt_h;
  assign mem_rd_addr_o = gnt_u ? head_flow : (gnt_h ? rd_flow : '0);
  assign rd_busy_o     = busy;
  assign mem_wr_en_o   = s2_wr;
  assign mem_wr_addr_o = s2_addr;
  assign mem_wr_data_o = s2_data;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {upd_flow_i, upd_size_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (upd_en_i && !push && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy    <= 1'b0;
      issued  <= 1'b0;
      rd_flow <= '0;
    end else if (rd_stb_i && !busy) begin
      busy    <= 1'b1;
      issued  <= 1'b0;
      rd_flow <= rd_flow_num_i;
    end else begin
      if (gnt_h)                busy   <= busy;
      if (gnt_h)                issued <= 1'b1;
      if (s1_valid && s1_host)  busy   <= 1'b0;
    end
  end

  // The younger in-flight write (S2) takes precedence over the one already in RAM-write (S3)
  always_comb begin
    old_val = mem_rd_data_i;
    if (s2_wr && (s2_addr == s1_addr))         old_val = s2_data;
    else if (s3_valid && (s3_addr == s1_addr)) old_val = s3_data;
    sum_ext = {1'b0, old_val} + {{(D_WIDTH + 1 - 16){1'b0}}, s1_size};
    sum_sat = sum_ext[D_WIDTH] ? {D_WIDTH{1'b1}} : sum_ext[D_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid      <= 1'b0;
      s1_host       <= 1'b0;
      s1_addr       <= '0;
      s1_size       <= '0;
      s2_wr         <= 1'b0;
      s2_addr       <= '0;
      s2_data       <= '0;
      rd_data_o     <= '0;
      rd_data_val_o <= 1'b0;
      s3_valid      <= 1'b0;
      s3_addr       <= '0;
      s3_data       <= '0;
    end else begin
      s1_valid      <= gnt_u | gnt_h;
      s1_host       <= gnt_h;
      s1_addr       <= mem_rd_addr_o;
      s1_size       <= gnt_u ? head_size : 16'd0;
      s2_wr         <= s1_valid && (!s1_host || (CLR_ON_RD != 0));
      rd_data_val_o <= s1_valid && s1_host;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_data <= s1_host ? ((CLR_ON_RD != 0) ? '0 : old_val) : sum_sat;
      end
      if (s1_valid && s1_host) rd_data_o <= old_val;
      s3_valid <= s2_wr;
      s3_addr  <= s2_addr;
      s3_data  <= s2_data;
    end
  end

endmodule

// File: tb/tb_stat_mem_arbiter.sv
// Scoreboarded bench for stat_mem_arbiter: two instances (plain and clear-on-read),
// each with a 1R/1W read-old-data RAM model and a reference FIFO occupancy model.
`timescale 1ns/1ps

module tb_stat_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [AW-1:0] upd_flow, rd_flow, m_rd_addr, m_wr_addr;
  logic [15:0]   upd_size, drop_cnt;
  logic          upd_en, rd_stb, rd_busy, rd_val, m_rd_en, m_wr_en, fifo_full;
  logic [DW-1:0] rd_data, m_rd_data, m_wr_data;

  logic [AW-1:0] upd_flow_c, rd_flow_c, m_rd_addr_c, m_wr_addr_c;
  logic [15:0]   upd_size_c, drop_cnt_c;
  logic          upd_en_c, rd_stb_c, rd_busy_c, rd_val_c, m_rd_en_c, m_wr_en_c, fifo_full_c;
  logic [DW-1:0] rd_data_c, m_rd_data_c, m_wr_data_c;

  stat_mem_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLR_ON_RD(0)) dut (
    .clk_i(clk), .rst_i(rst_n), .upd_flow_i(upd_flow), .upd_size_i(upd_size), .upd_en_i(upd_en),
    .rd_stb_i(rd_stb), .rd_flow_num_i(rd_flow), .rd_busy_o(rd_busy), .rd_data_o(rd_data),
    .rd_data_val_o(rd_val), .mem_rd_en_o(m_rd_en), .mem_rd_addr_o(m_rd_addr),
    .mem_rd_data_i(m_rd_data), .mem_wr_en_o(m_wr_en), .mem_wr_addr_o(m_wr_addr),
    .mem_wr_data_o(m_wr_data), .fifo_full_o(fifo_full), .drop_cnt_o(drop_cnt));

  stat_mem_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLR_ON_RD(1)) dut_c (
    .clk_i(clk), .rst_i(rst_n), .upd_flow_i(upd_flow_c), .upd_size_i(upd_size_c), .upd_en_i(upd_en_c),
    .rd_stb_i(rd_stb_c), .rd_flow_num_i(rd_flow_c), .rd_busy_o(rd_busy_c), .rd_data_o(rd_data_c),
    .rd_data_val_o(rd_val_c), .mem_rd_en_o(m_rd_en_c), .mem_rd_addr_o(m_rd_addr_c),
    .mem_rd_data_i(m_rd_data_c), .mem_wr_en_o(m_wr_en_c), .mem_wr_addr_o(m_wr_addr_c),
    .mem_wr_data_o(m_wr_data_c), .fifo_full_o(fifo_full_c), .drop_cnt_o(drop_cnt_c));

  logic [DW-1:0] ram   [0:(1<<AW)-1];
  logic [DW-1:0] ram_c [0:(1<<AW)-1];
  logic          ram_init, pre_we, pre_we_c;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (m_rd_en) m_rd_data <= ram[m_rd_addr];
    if (ram_init) for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
    else if (pre_we) ram[pre_addr] <= pre_data;
    else if (m_wr_en) ram[m_wr_addr] <= m_wr_data;
  end

  always @(posedge clk) begin
    if (m_rd_en_c) m_rd_data_c <= ram_c[m_rd_addr_c];
    if (ram_init) for (int i = 0; i < (1<<AW); i++) ram_c[i] <= '0;
    else if (pre_we_c) ram_c[pre_addr] <= pre_data;
    else if (m_wr_en_c) ram_c[m_wr_addr_c] <= m_wr_data_c;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read-result scoreboards
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_qc[$];
  logic prev_val = 1'b0, prev_val_c = 1'b0;

  always @(negedge clk) begin
    if (rd_val) begin
      check_eq("rd_pulse_len", prev_val, 0);
      check_eq("rd_busy_at_val", rd_busy, 0);
      if (exp_q.size() == 0) check_eq("rd_spurious", rd_val, 0);
      else check_eq("rd_data", rd_data, exp_q.pop_front());
    end
    prev_val <= rd_val;
  end

  always @(negedge clk) begin
    if (rd_val_c) begin
      if (exp_qc.size() == 0) check_eq("rdc_spurious", rd_val_c, 0);
      else check_eq("rdc_data", rd_data_c, exp_qc.pop_front());
    end
    prev_val_c <= rd_val_c;
  end

  // Reference FIFO occupancy model; pops are recognised by the update flow address
  logic          fm_on = 1'b0;
  logic [AW-1:0] fm_flow = '0;
  int occ = 0, acc_cnt = 0, drop_exp = 0;

  task automatic fifo_model_step();
    logic pop_m;
    pop_m = m_rd_en && (m_rd_addr == fm_flow);
    check_eq("fifo_full", fifo_full, occ == DEPTH);
    if (upd_en) begin
      if (occ < DEPTH || pop_m) begin
        acc_cnt++;
        occ++;
      end else drop_exp++;
    end
    if (pop_m) occ--;
  endtask

  always @(negedge clk) if (fm_on) fifo_model_step();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [AW-1:0] f, input logic [15:0] s);
    upd_flow = f; upd_size = s; upd_en = 1'b1;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic host_rd(input logic [AW-1:0] f, input logic [DW-1:0] e);
    int k = 0;
    while (rd_busy && k < 50) begin tick(); k++; end
    check_eq("rd_wait_timeout", k < 50, 1);
    rd_flow = f; rd_stb = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_stb = 1'b0;
  endtask

  task automatic wait_idle(input int extra);
    int k = 0;
    while ((rd_busy || exp_q.size() != 0) && k < 100) begin tick(); k++; end
    check_eq("idle_timeout", k < 100, 1);
    repeat (extra) tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"}, {rd_busy, rd_val, m_rd_en, m_wr_en, fifo_full}, 0);
    check_eq({tag, "_rd_data"}, rd_data, 0);
    check_eq({tag, "_addrs"}, {m_rd_addr, m_wr_addr}, 0);
    check_eq({tag, "_wr_data"}, m_wr_data, 0);
    check_eq({tag, "_drop"}, drop_cnt, 0);
  endtask

  logic upd_done;

  task automatic contend(input int n, input logic [AW-1:0] f, input logic [15:0] s);
    upd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          upd_flow = f; upd_size = s; upd_en = 1'b1;
          tick();
        end
        upd_en = 1'b0;
        upd_done = 1'b1;
      end
      begin
        while (!upd_done) begin
          int lat;
          rd_flow = 10'd4; rd_stb = 1'b1;
          exp_q.push_back(32'd6);
          tick();
          rd_stb = 1'b0;
          lat = 1;
          while (!rd_val && lat < 20) begin tick(); lat++; end
          check_eq("rd_fair_latency", lat <= 4, 1);
        end
      end
    join
  endtask

  int acc0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ram_init = 1'b1; pre_we = 1'b0; pre_we_c = 1'b0;
    pre_addr = '0; pre_data = '0;
    upd_flow = '0; upd_size = '0; upd_en = 1'b0; rd_stb = 1'b0; rd_flow = '0;
    upd_flow_c = '0; upd_size_c = '0; upd_en_c = 1'b0; rd_stb_c = 1'b0; rd_flow_c = '0;
    tick(); tick();
    ram_init = 1'b0;
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back updates on one flow, then an uncontended read
    upd(10'd4, 16'd1); upd(10'd4, 16'd2); upd(10'd4, 16'd3);
    host_rd(10'd4, 32'd6);
    tick(); tick();
    check_eq("rd_latency3", rd_val, 1);
    tick();
    check_eq("rd_val_one_cycle", rd_val, 0);
    check_eq("rd_busy_after", rd_busy, 0);

    // Saturation
    pre_addr = 10'd7; pre_data = 32'hFFFF_FFF0; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
    upd(10'd7, 16'h0020);
    tick(); tick();
    check_eq("sat_wr_en", m_wr_en, 1);
    check_eq("sat_wr_addr", m_wr_addr, 7);
    check_eq("sat_wr_data", m_wr_data, 32'hFFFF_FFFF);
    host_rd(10'd7, 32'hFFFF_FFFF);
    wait_idle(4);

    // Contention: short burst without drops, then a long burst that overflows
    fm_flow = 10'd20; fm_on = 1'b1;
    contend(12, 10'd20, 16'd3);
    wait_idle(16);
    check_eq("dropA", drop_cnt, 0);
    check_eq("ram20", ram[20], 32'd36);
    acc0 = acc_cnt;
    fm_flow = 10'd30;
    contend(60, 10'd30, 16'd1);
    wait_idle(16);
    fm_on = 1'b0;
    check_eq("dropB", drop_cnt, drop_exp);
    check_eq("drops_seen", drop_cnt != 0, 1);
    check_eq("ram30", ram[30], acc_cnt - acc0);

    // Interleaved update / read / update on one flow
    upd_flow = 10'd40; upd_size = 16'd5; upd_en = 1'b1;
    tick();
    upd_en = 1'b0; rd_flow = 10'd40; rd_stb = 1'b1;
    exp_q.push_back(32'd5);
    tick();
    rd_stb = 1'b0; upd_en = 1'b1;
    tick();
    upd_en = 1'b0;
    wait_idle(6);
    check_eq("ram40", ram[40], 32'd10);

    // Clear-on-read instance
    pre_addr = 10'd9; pre_data = 32'd100; pre_we_c = 1'b1;
    tick();
    pre_we_c = 1'b0;
    rd_flow_c = 10'd9; rd_stb_c = 1'b1;
    exp_qc.push_back(32'd100);
    tick();
    rd_stb_c = 1'b0; upd_flow_c = 10'd9; upd_size_c = 16'd1; upd_en_c = 1'b1;
    tick();
    upd_en_c = 1'b0;
    tick();
    check_eq("clr_wr", {m_wr_en_c, m_wr_addr_c}, {1'b1, 10'd9});
    check_eq("clr_wr_data", m_wr_data_c, 0);
    tick();
    check_eq("clr_upd_wr", {m_wr_en_c, m_wr_addr_c}, {1'b1, 10'd9});
    check_eq("clr_upd_data", m_wr_data_c, 1);
    repeat (4) tick();
    check_eq("ramc9", ram_c[9], 32'd1);

    // Reset while a host read is in flight
    rd_flow = 10'd4; rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    check_eq("busy_set", rd_busy, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("post_rst_idle", {rd_busy, rd_val}, 0);
    host_rd(10'd4, 32'd6);
    wait_idle(4);
    check_eq("ram4", ram[4], 32'd6);

    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("exp_qc_drained", exp_qc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
